// File: rtl/weight_fetch_if.sv
// Request, RAM read port and weight stream bundled for the weight fetch sequencer.
// master = sequencer side, slave = environment (request source, RAM, neuron datapath).
interface weight_fetch_if #(
  parameter int AW = 14,
  parameter int DW = 32,
  parameter int LW = 14
);
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] len;
  logic          busy;
  logic          done;
  logic          err;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout;
  logic          w_valid;
  logic          w_ready;
  logic [DW-1:0] w_data;
  logic          w_last;

  modport master (
    input  start, base_addr, len, ram_dout, w_ready,
    output busy, done, err, ram_en, ram_we, ram_addr, w_valid, w_data, w_last
  );

  modport slave (
    output start, base_addr, len, ram_dout, w_ready,
    input  busy, done, err, ram_en, ram_we, ram_addr, w_valid, w_data, w_last
  );
endinterface

// File: rtl/weight_fetch.sv
// Weight RAM read sequencer: issues back-to-back reads for a (base, len) request
// and streams the words out through a small skid buffer that hides the read latency.
module weight_fetch #(
  parameter int AW       = 14,
  parameter int DW       = 32,
  parameter int LW       = 14,
  parameter int ADDR_MIN = 10,
  parameter int ADDR_MAX = 12287,
  parameter int DEPTH    = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  weight_fetch_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = ((AW > LW) ? AW : LW) + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } entry_t;

  state_t               state;
  logic [AW-1:0]        base_q;
  logic [AW-1:0]        addr_hold;
  logic [LW-1:0]        len_q;
  logic [LW-1:0]        issued;
  logic                 inflight;
  logic                 inflight_last;
  logic [CW-1:0]        count;
  entry_t [DEPTH-1:0]   fifo;
  entry_t [DEPTH-1:0]   shifted;
  logic                 busy_q, done_q, err_q;

  logic [SW-1:0]        req_end;
  logic                 req_ok;
  logic                 pop;
  logic [CW:0]          occ;
  logic                 issue;
  logic                 final_issue;
  logic [CW-1:0]        wr_idx;
  logic [AW-1:0]        cur_addr;

  // End address is formed one bit wider so a huge len cannot wrap back into range.
  assign req_end = SW'(bus.base_addr) + SW'(bus.len) - SW'(1);
  assign req_ok  = (bus.len != '0) && (bus.base_addr >= AW'(ADDR_MIN)) &&
                   (req_end <= SW'(ADDR_MAX));

  assign pop = (count != '0) && bus.w_ready;

  // Slots already committed (buffered + read in flight) after this cycle's pop.
  assign occ         = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue       = (state == FETCH) && (issued < len_q) && (occ < (CW+1)'(DEPTH));
  assign final_issue = issue && (issued == len_q - LW'(1));
  assign cur_addr    = base_q + AW'(issued);
  assign wr_idx      = count - CW'(pop);
  assign shifted     = {entry_t'('0), fifo[DEPTH-1:1]};

  assign bus.ram_en   = issue;
  assign bus.ram_we   = 1'b0;
  assign bus.ram_addr = issue ? cur_addr : addr_hold;
  assign bus.w_valid  = (count != '0);
  assign bus.w_data   = fifo[0].data;
  assign bus.w_last   = fifo[0].last;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      base_q        <= '0;
      len_q         <= '0;
      issued        <= '0;
      addr_hold     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      inflight      <= issue;
      inflight_last <= final_issue;
      if (issue) begin
        issued    <= issued + LW'(1);
        addr_hold <= cur_addr;
      end
      case (state)
        IDLE: if (bus.start) begin
          if (req_ok) begin
            state  <= FETCH;
            base_q <= bus.base_addr;
            len_q  <= bus.len;
            issued <= '0;
            busy_q <= 1'b1;
          end else begin
            err_q <= 1'b1;
          end
        end
        FETCH: if (final_issue) state <= DRAIN;
        DRAIN: if (pop && fifo[0].last) begin
          state  <= DONE;
          done_q <= 1'b1;
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Head-at-0 shift buffer; a pop clears the top slot so idle entries never carry a stale last tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo  <= '0;
      count <= '0;
    end else begin
      count <= count + CW'(inflight) - CW'(pop);
      for (int i = 0; i < DEPTH; i++) begin
        if (inflight && (wr_idx == CW'(i))) begin
          fifo[i].last <= inflight_last;
          fifo[i].data <= bus.ram_dout;
        end else if (pop) begin
          fifo[i] <= shifted[i];
        end
      end
    end
  end
endmodule

// File: tb/tb_weight_fetch.sv
// Self-checking bench for weight_fetch: RAM model, stream monitor and a
// request-level reference model (address arithmetic and latency formulas).
module tb_weight_fetch;
  localparam int DEPTH = 2;

  logic clk;
  logic rst_n;

  weight_fetch_if #(.AW(14), .DW(32), .LW(14)) bus ();

  weight_fetch #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;
  int rmode = 0;
  bit timeout;

  logic [13:0] en_addr[$];
  int          en_cyc[$];
  logic [31:0] pop_data[$];
  bit          pop_last[$];
  int          pop_cyc[$];
  int          done_cyc[$];
  int          err_cyc[$];
  int          busy_cyc[$];
  int          stab_err = 0;
  int          occ_viol = 0;
  int          we_err = 0;

  int m_en, m_pop, m_done, m_err, m_busy, m_stab, m_occ;

  // RAM content: low half is the address, high half its complement.
  function automatic logic [31:0] word(int a);
    logic [15:0] v;
    v = 16'(a);
    return {~v, v};
  endfunction

  function automatic bit req_ok(int b, int l);
    return (l != 0) && (b >= 10) && (b + l - 1 <= 12287);
  endfunction

  function automatic int stream_bad(int b, int l);
    int bad = 0;
    if (pop_data.size() - m_pop != l) return l + 1;
    for (int k = 0; k < l; k++)
      if (pop_data[m_pop+k] !== word(b + k) || pop_last[m_pop+k] !== (k == l - 1)) bad++;
    return bad;
  endfunction

  function automatic int en_bad(int b, int l);
    int bad = 0;
    if (en_addr.size() - m_en != l) return l + 1;
    for (int k = 0; k < l; k++)
      if (en_addr[m_en+k] !== 14'(b + k)) bad++;
    return bad;
  endfunction

  function automatic logic ready_bit();
    case (rmode)
      0:       return 1'b1;
      1:       return ((cyc - t0) % 3) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    bus.ram_dout = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      if (bus.ram_en && !bus.ram_we) bus.ram_dout <= word(int'(bus.ram_addr));
    end
  end

  // Monitor: logs every observable event; outstanding = reads issued but not yet popped.
  initial begin
    int   outstanding;
    bit   prev_stall;
    logic [31:0] prev_data;
    logic prev_last;
    outstanding = 0;
    prev_stall = 0;
    prev_data = '0;
    prev_last = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        outstanding = 0;
        prev_stall = 0;
      end else begin
        if (bus.ram_we) we_err++;
        if (bus.ram_en) begin
          en_addr.push_back(bus.ram_addr);
          en_cyc.push_back(cyc);
          outstanding++;
        end
        if (bus.w_valid && bus.w_ready) begin
          pop_data.push_back(bus.w_data);
          pop_last.push_back(bus.w_last);
          pop_cyc.push_back(cyc);
          outstanding--;
        end
        if (outstanding > DEPTH) occ_viol++;
        if (prev_stall && (!bus.w_valid || bus.w_data !== prev_data || bus.w_last !== prev_last))
          stab_err++;
        prev_stall = bus.w_valid && !bus.w_ready;
        prev_data  = bus.w_data;
        prev_last  = bus.w_last;
        if (bus.done) done_cyc.push_back(cyc);
        if (bus.err)  err_cyc.push_back(cyc);
        if (bus.busy) busy_cyc.push_back(cyc);
      end
    end
  end

  task automatic mark();
    m_en = en_addr.size();   m_pop = pop_data.size(); m_done = done_cyc.size();
    m_err = err_cyc.size();  m_busy = busy_cyc.size(); m_stab = stab_err; m_occ = occ_viol;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.w_ready = ready_bit();
  endtask

  task automatic kick(int b, int l);
    bus.start = 1'b1;
    bus.base_addr = 14'(b);
    bus.len = 14'(l);
    t0 = cyc;
    bus.w_ready = ready_bit();
  endtask

  task automatic run_req(int b, int l, int inj_rel, int inj_base);
    mark();
    step();
    kick(b, l);
    timeout = 1;
    for (int k = 0; k < 400; k++) begin
      step();
      if (inj_rel > 0 && cyc - t0 == inj_rel) begin
        bus.start = 1'b1;
        bus.base_addr = 14'(inj_base);
        bus.len = 14'd3;
      end
      if (done_cyc.size() > m_done || err_cyc.size() > m_err) begin
        timeout = 0;
        break;
      end
    end
    step();
    step();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.err, bus.ram_en, bus.ram_we, bus.w_valid, bus.w_last} !== 7'b0)
      begin failures++; $display("FAIL reset_flags: got %b expected 0000000",
        {bus.busy, bus.done, bus.err, bus.ram_en, bus.ram_we, bus.w_valid, bus.w_last}); end
    checks++;
    if (bus.ram_addr !== 14'd0) begin failures++;
      $display("FAIL reset_ram_addr: got %0d expected 0", bus.ram_addr); end
    checks++;
    if (bus.w_data !== 32'd0) begin failures++;
      $display("FAIL reset_w_data: got %h expected 0", bus.w_data); end
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if ({bus.busy, bus.done, bus.err, bus.ram_en, bus.w_valid} !== 5'b0) begin failures++;
      $display("FAIL reset_release_idle: got %b expected 00000",
        {bus.busy, bus.done, bus.err, bus.ram_en, bus.w_valid}); end
  endtask

  task automatic test_basic();
    int bad, n, first, last, dc;
    rmode = 0;
    run_req(10, 4, -1, 0);
    checks++;
    if (timeout) begin failures++; $display("FAIL basic_timeout: no done/err within budget"); end
    checks++;
    bad = en_bad(10, 4);
    if (bad != 0) begin failures++; $display("FAIL basic_ram_addr: %0d bad of %0d issued, expected 10..13",
      bad, en_addr.size() - m_en); end
    bad = 0;
    for (int k = 0; k < en_addr.size() - m_en && k < 4; k++) if (en_cyc[m_en+k] - t0 != k + 1) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL basic_ram_en_cycle: %0d off-cycle issues, expected cycles 1..4", bad); end
    checks++;
    bad = stream_bad(10, 4);
    if (bad != 0) begin failures++; $display("FAIL basic_stream: %0d bad words of %0d, expected 10..13 last on 13",
      bad, pop_data.size() - m_pop); end
    bad = 0;
    for (int k = 0; k < pop_data.size() - m_pop && k < 4; k++) if (pop_cyc[m_pop+k] - t0 != k + 3) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL basic_stream_cycle: %0d words off-cycle, expected cycles 3..6", bad); end
    dc = (done_cyc.size() > m_done) ? done_cyc[m_done] - t0 : -1;
    checks++;
    if (done_cyc.size() - m_done != 1 || dc != 7) begin failures++;
      $display("FAIL basic_done: got cycle %0d count %0d, expected cycle 7 count 1", dc, done_cyc.size() - m_done); end
    n = busy_cyc.size() - m_busy;
    first = (n > 0) ? busy_cyc[m_busy] - t0 : -1;
    last  = (n > 0) ? busy_cyc[busy_cyc.size()-1] - t0 : -1;
    checks++;
    if (n != 7 || first != 1 || last != 7) begin failures++;
      $display("FAIL basic_busy: got %0d cycles %0d..%0d, expected 7 cycles 1..7", n, first, last); end
    checks++;
    if (err_cyc.size() != m_err) begin failures++; $display("FAIL basic_err: got %0d pulses expected 0",
      err_cyc.size() - m_err); end
  endtask

  task automatic test_backpressure();
    int bad;
    rmode = 1;
    run_req(100, 8, -1, 0);
    checks++;
    if (timeout) begin failures++; $display("FAIL bp_timeout: no done within budget"); end
    checks++;
    bad = stream_bad(100, 8);
    if (bad != 0) begin failures++; $display("FAIL bp_stream: %0d bad of %0d words, expected 100..107",
      bad, pop_data.size() - m_pop); end
    checks++;
    bad = en_bad(100, 8);
    if (bad != 0) begin failures++; $display("FAIL bp_ram_addr: %0d bad of %0d reads, expected 100..107",
      bad, en_addr.size() - m_en); end
    checks++;
    if (stab_err != m_stab) begin failures++; $display("FAIL bp_stall_stable: got %0d changes while stalled expected 0",
      stab_err - m_stab); end
    checks++;
    if (occ_viol != m_occ) begin failures++; $display("FAIL bp_occupancy: got %0d cycles above %0d expected 0",
      occ_viol - m_occ, DEPTH); end
    checks++;
    if (done_cyc.size() - m_done != 1) begin failures++; $display("FAIL bp_done: got %0d pulses expected 1",
      done_cyc.size() - m_done); end
    rmode = 0;
  endtask

  task automatic test_boundaries();
    int bb[4] = '{12287, 9, 10, 16000};
    int bl[4] = '{2, 1, 0, 1000};
    int bad, pc, dc;
    rmode = 0;
    run_req(12287, 1, -1, 0);
    checks++;
    bad = stream_bad(12287, 1);
    pc = (pop_cyc.size() > m_pop) ? pop_cyc[m_pop] - t0 : -1;
    if (timeout || bad != 0 || pc != 3) begin failures++;
      $display("FAIL bnd_top_single: bad=%0d cycle=%0d timeout=%0d, expected bad=0 cycle=3", bad, pc, timeout); end
    checks++;
    dc = (done_cyc.size() > m_done) ? done_cyc[m_done] - t0 : -1;
    if (dc != 4 || err_cyc.size() != m_err) begin failures++;
      $display("FAIL bnd_top_done: got done cycle %0d err %0d, expected 4 and 0", dc, err_cyc.size() - m_err); end
    run_req(12278, 10, -1, 0);
    checks++;
    bad = stream_bad(12278, 10);
    if (timeout || bad != 0 || err_cyc.size() != m_err) begin failures++;
      $display("FAIL bnd_top_range: bad=%0d err=%0d, expected 0 and 0", bad, err_cyc.size() - m_err); end
    for (int i = 0; i < 4; i++) begin
      run_req(bb[i], bl[i], -1, 0);
      dc = (err_cyc.size() > m_err) ? err_cyc[m_err] - t0 : -1;
      checks++;
      if (err_cyc.size() - m_err != 1 || dc != 1) begin failures++;
        $display("FAIL bnd_err_%0d_%0d: got %0d pulses at cycle %0d, expected 1 at cycle 1",
          bb[i], bl[i], err_cyc.size() - m_err, dc); end
      checks++;
      if (en_addr.size() != m_en || busy_cyc.size() != m_busy || pop_data.size() != m_pop) begin failures++;
        $display("FAIL bnd_quiet_%0d_%0d: got en=%0d busy=%0d words=%0d expected 0 0 0", bb[i], bl[i],
          en_addr.size() - m_en, busy_cyc.size() - m_busy, pop_data.size() - m_pop); end
    end
  endtask

  task automatic test_start_while_busy();
    int bad, nb;
    rmode = 0;
    run_req(50, 6, 2, 300);
    checks++;
    bad = stream_bad(50, 6);
    if (timeout || bad != 0) begin failures++;
      $display("FAIL busy_start_stream: bad=%0d words=%0d, expected 6 words 50..55", bad, pop_data.size() - m_pop); end
    checks++;
    bad = en_bad(50, 6);
    if (bad != 0) begin failures++; $display("FAIL busy_start_reads: %0d bad of %0d reads", bad, en_addr.size() - m_en); end
    checks++;
    if (err_cyc.size() != m_err || done_cyc.size() - m_done != 1) begin failures++;
      $display("FAIL busy_start_flags: err=%0d done=%0d expected 0 and 1", err_cyc.size() - m_err, done_cyc.size() - m_done); end
    nb = busy_cyc.size();
    repeat (4) step();
    checks++;
    if (busy_cyc.size() != nb || en_addr.size() - m_en != 6) begin failures++;
      $display("FAIL busy_start_ignored: extra busy %0d reads %0d expected 0 and 6", busy_cyc.size() - nb, en_addr.size() - m_en); end
  endtask

  task automatic test_reset_mid();
    int p_rel, e_rel, bad;
    rmode = 0;
    mark();
    step();
    kick(1000, 10);
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.err, bus.ram_en, bus.w_valid, bus.w_last} !== 6'b0 ||
        bus.ram_addr !== 14'd0 || bus.w_data !== 32'd0) begin failures++;
      $display("FAIL midreset_outputs: flags %b addr %0d data %h expected all 0",
        {bus.busy, bus.done, bus.err, bus.ram_en, bus.w_valid, bus.w_last}, bus.ram_addr, bus.w_data); end
    step();
    step();
    checks++;
    if ({bus.busy, bus.ram_en, bus.w_valid} !== 3'b0) begin failures++;
      $display("FAIL midreset_held: flags %b expected 000", {bus.busy, bus.ram_en, bus.w_valid}); end
    rst_n = 1'b1;
    p_rel = pop_data.size();
    e_rel = en_addr.size();
    run_req(200, 2, -1, 0);
    checks++;
    bad = stream_bad(200, 2);
    if (timeout || bad != 0 || pop_data.size() - p_rel != 2) begin failures++;
      $display("FAIL midreset_restream: bad=%0d words since release=%0d expected 0 and 2", bad, pop_data.size() - p_rel); end
    checks++;
    if (en_addr.size() - e_rel != 2) begin failures++;
      $display("FAIL midreset_reads: got %0d reads expected 2", en_addr.size() - e_rel); end
  endtask

  task automatic test_back_to_back();
    int bad, dc, n, first, fe, fp, lp;
    rmode = 0;
    mark();
    step();
    kick(500, 3);
    timeout = 1;
    for (int k = 0; k < 100; k++) begin
      step();
      if (done_cyc.size() > m_done) begin timeout = 0; break; end
    end
    checks++;
    bad = stream_bad(500, 3);
    dc = (done_cyc.size() > m_done) ? done_cyc[m_done] - t0 : -1;
    if (timeout || bad != 0 || dc != 6) begin failures++;
      $display("FAIL b2b_first: bad=%0d done cycle %0d expected 0 and 6", bad, dc); end
    mark();
    kick(700, 5);
    timeout = 1;
    for (int k = 0; k < 100; k++) begin
      step();
      if (done_cyc.size() > m_done) begin timeout = 0; break; end
    end
    step();
    step();
    checks++;
    bad = stream_bad(700, 5);
    if (timeout || bad != 0) begin failures++; $display("FAIL b2b_second_stream: bad=%0d timeout=%0d expected 0", bad, timeout); end
    fe = (en_cyc.size() > m_en) ? en_cyc[m_en] - t0 : -1;
    fp = (pop_cyc.size() > m_pop) ? pop_cyc[m_pop] - t0 : -1;
    lp = (pop_cyc.size() > m_pop) ? pop_cyc[pop_cyc.size()-1] - t0 : -1;
    dc = (done_cyc.size() > m_done) ? done_cyc[m_done] - t0 : -1;
    checks++;
    if (fe != 1 || fp != 3 || lp != 7 || dc != 8) begin failures++;
      $display("FAIL b2b_latency: got en %0d first %0d last %0d done %0d expected 1 3 7 8", fe, fp, lp, dc); end
    n = busy_cyc.size() - m_busy;
    first = (n > 0) ? busy_cyc[m_busy] - t0 : -1;
    checks++;
    if (n != 8 || first != 1) begin failures++;
      $display("FAIL b2b_busy: got %0d cycles from %0d expected 8 from 1", n, first); end
  endtask

  task automatic test_random();
    int b, l, bad;
    rmode = 2;
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 3))
        0: begin b = $urandom_range(10, 12000);    l = $urandom_range(1, 12);    end
        1: begin b = $urandom_range(12270, 12287); l = $urandom_range(1, 20);    end
        2: begin b = $urandom_range(0, 14);        l = $urandom_range(0, 4);     end
        default: begin b = $urandom_range(12288, 16383); l = $urandom_range(0, 16383); end
      endcase
      run_req(b, l, -1, 0);
      if (req_ok(b, l)) begin
        bad = stream_bad(b, l) + en_bad(b, l);
        checks++;
        if (timeout || bad != 0 || err_cyc.size() != m_err || done_cyc.size() - m_done != 1) begin failures++;
          $display("FAIL rand_ok base=%0d len=%0d: bad=%0d err=%0d done=%0d timeout=%0d", b, l, bad,
            err_cyc.size() - m_err, done_cyc.size() - m_done, timeout); end
      end else begin
        checks++;
        if (err_cyc.size() - m_err != 1 || en_addr.size() != m_en || busy_cyc.size() != m_busy ||
            pop_data.size() != m_pop) begin failures++;
          $display("FAIL rand_reject base=%0d len=%0d: err=%0d en=%0d busy=%0d words=%0d expected 1 0 0 0", b, l,
            err_cyc.size() - m_err, en_addr.size() - m_en, busy_cyc.size() - m_busy, pop_data.size() - m_pop); end
      end
      checks++;
      if (stab_err != m_stab || occ_viol != m_occ) begin failures++;
        $display("FAIL rand_stream_rules base=%0d len=%0d: stall changes %0d overfill %0d expected 0 0", b, l,
          stab_err - m_stab, occ_viol - m_occ); end
    end
    rmode = 0;
  endtask

  initial begin
    rst_n = 1'b1;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.len = '0;
    bus.w_ready = 1'b1;
    #2 rst_n = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_boundaries();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    checks++;
    if (we_err != 0) begin failures++; $display("FAIL ram_we_tied: got %0d cycles with ram_we=1 expected 0", we_err); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
